// File: rtl/phase_sequencer_if.sv
// Control and status bundle for the phase sequencer.
// The master drives the sequencing controls and the slave (the sequencer) returns phase status.
interface phase_sequencer_if #(
  parameter int NPHASE = 5,
  parameter int IDX_W  = 3,
  parameter int CYC_W  = 32
);
  logic              run;
  logic              step;
  logic              stall;
  logic              restart;
  logic [NPHASE-1:0] skip_mask;
  logic [NPHASE-1:0] phase_en;
  logic [IDX_W-1:0]  phase_idx;
  logic              cycle_start;
  logic              cycle_end;
  logic [CYC_W-1:0]  cycle_count;
  logic              busy;

  modport master (
    output run, step, stall, restart, skip_mask,
    input  phase_en, phase_idx, cycle_start, cycle_end, cycle_count, busy
  );

  modport slave (
    input  run, step, stall, restart, skip_mask,
    output phase_en, phase_idx, cycle_start, cycle_end, cycle_count, busy
  );
endinterface

// File: rtl/phase_sequencer.sv
// Sub-cycle phase sequencer: emits one-hot synchronous phase enables per instruction cycle,
// with skippable phases, stall, restart, single-step and a completed-cycle counter.
module phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int IDX_W  = 3,
  parameter int CYC_W  = 32
) (
  input logic              clk,
  input logic              rst,
  phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [NPHASE-1:0] EN0 = {{(NPHASE-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]  ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [IDX_W-1:0] nxt_idx_s;
  logic [IDX_W-1:0] last_idx_s;
  logic             has_nxt_s;

  // Lowest non-skipped phase above the current one, and the highest non-skipped phase overall
  always_comb begin
    nxt_idx_s  = {IDX_W{1'b0}};
    last_idx_s = {IDX_W{1'b0}};
    has_nxt_s  = 1'b0;
    for (int i = NPHASE - 1; i >= 1; i--) begin
      nxt_idx_s = (!bus.skip_mask[i] && (IDX_W'(i) > bus.phase_idx)) ? IDX_W'(i) : nxt_idx_s;
      has_nxt_s = has_nxt_s | (!bus.skip_mask[i] && (IDX_W'(i) > bus.phase_idx));
    end
    for (int i = 1; i < NPHASE; i++) begin
      last_idx_s = (!bus.skip_mask[i]) ? IDX_W'(i) : last_idx_s;
    end
  end

  assign bus.busy        = (state_r != IDLE);
  assign bus.cycle_start = (state_r != IDLE) && (bus.phase_idx == {IDX_W{1'b0}});
  assign bus.cycle_end   = (state_r != IDLE) && (bus.phase_idx == last_idx_s);

  // Sequencer state, phase registers and completed-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      bus.phase_idx   <= {IDX_W{1'b0}};
      bus.phase_en    <= {NPHASE{1'b0}};
      bus.cycle_count <= {CYC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.stall && (bus.run || bus.step)) begin
            state_r       <= bus.run ? RUN : STEP;
            bus.phase_idx <= {IDX_W{1'b0}};
            bus.phase_en  <= EN0;
          end
        end
        RUN, STEP: begin
          if (bus.restart) begin
            bus.phase_idx <= {IDX_W{1'b0}};
            bus.phase_en  <= EN0;
          end else if (!bus.stall) begin
            if (has_nxt_s) begin
              bus.phase_idx <= nxt_idx_s;
              bus.phase_en  <= EN0 << nxt_idx_s;
            end else begin
              // Leaving the last active phase completes the cycle; run is only sampled here
              bus.cycle_count <= bus.cycle_count + ONE;
              bus.phase_idx   <= {IDX_W{1'b0}};
              if ((state_r == RUN) && bus.run) begin
                bus.phase_en <= EN0;
              end else begin
                state_r      <= IDLE;
                bus.phase_en <= {NPHASE{1'b0}};
              end
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          bus.phase_idx <= {IDX_W{1'b0}};
          bus.phase_en  <= {NPHASE{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: an abstract cycle model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_phase_sequencer;
  localparam int NP = 5;
  localparam int IW = 3;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   chk_on;

  // model: mode 0 = idle, 1 = run, 2 = step
  int m_mode;
  int m_ph;
  int m_cnt;

  phase_sequencer_if #(.NPHASE(NP), .IDX_W(IW), .CYC_W(CW)) bus ();

  phase_sequencer #(.NPHASE(NP), .IDX_W(IW), .CYC_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int last_active(logic [NP-1:0] m);
    int r;
    r = 0;
    for (int i = 1; i < NP; i++) if (!m[i]) r = i;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference behaviour: one instruction cycle walks the non-skipped phases upward
  always @(posedge clk) begin
    int s, p, c;
    s = m_mode; p = m_ph; c = m_cnt;
    if (rst) begin
      s = 0; p = 0; c = 0;
    end else if (s == 0) begin
      if (!bus.stall && (bus.run || bus.step)) begin
        s = bus.run ? 1 : 2;
        p = 0;
      end
    end else if (bus.restart) begin
      p = 0;
    end else if (!bus.stall) begin
      if (p >= last_active(bus.skip_mask)) begin
        c = (c + 1) % (1 << CW);
        p = 0;
        if (!(s == 1 && bus.run)) s = 0;
      end else begin
        p = p + 1;
        while (bus.skip_mask[p]) p = p + 1;
      end
    end
    m_mode <= s; m_ph <= p; m_cnt <= c;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_en",    32'(bus.phase_en),    (m_mode != 0) ? (32'd1 << m_ph) : 32'd0);
      chk("model_idx",   32'(bus.phase_idx),   (m_mode != 0) ? 32'(m_ph) : 32'd0);
      chk("model_start", 32'(bus.cycle_start), 32'((m_mode != 0) && (m_ph == 0)));
      chk("model_end",   32'(bus.cycle_end),   32'((m_mode != 0) && (m_ph == last_active(bus.skip_mask))));
      chk("model_count", 32'(bus.cycle_count), 32'(m_cnt));
      chk("model_busy",  32'(bus.busy),        32'(m_mode != 0));
    end
  end

  initial begin
    total = 0; bad = 0; chk_on = 1'b0;
    rst = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0; bus.stall = 1'b0; bus.restart = 1'b0;
    bus.skip_mask = 5'b00000;
    tick(1);
    chk_on = 1'b1;
    tick(1);
    chk("rst_en",    32'(bus.phase_en),    32'd0);
    chk("rst_count", 32'(bus.cycle_count), 32'd0);
    chk("rst_busy",  32'(bus.busy),        32'd0);

    // free run
    rst = 1'b0; bus.run = 1'b1;
    tick(1);  chk("run_e1_en",   32'(bus.phase_en), 32'b00001);
    tick(2);  chk("run_e3_en",   32'(bus.phase_en), 32'b00100);
    tick(8);  chk("run_e11_cnt", 32'(bus.cycle_count), 32'd2);
    chk("run_e11_en", 32'(bus.phase_en), 32'b00001);
    tick(1);  chk("run_e12_en",  32'(bus.phase_en), 32'b00010);

    // run dropped at idx 1: phases 2..4 still complete
    bus.run = 1'b0;
    tick(3);  chk("drop_en4",  32'(bus.phase_en), 32'b10000);
    chk("drop_busy", 32'(bus.busy), 32'd1);
    tick(1);  chk("drop_idle", 32'(bus.busy), 32'd0);
    chk("drop_cnt", 32'(bus.cycle_count), 32'd3);

    // single step, with a stray step pulse while busy
    bus.step = 1'b1; tick(1); bus.step = 1'b0;
    chk("step_en0", 32'(bus.phase_en), 32'b00001);
    tick(2);
    bus.step = 1'b1; tick(1); bus.step = 1'b0;
    chk("step_idx3", 32'(bus.phase_idx), 32'd3);
    tick(1);
    tick(1);  chk("step_idle", 32'(bus.busy), 32'd0);
    chk("step_en_off", 32'(bus.phase_en), 32'd0);
    chk("step_cnt", 32'(bus.cycle_count), 32'd4);

    // skipped phases 1 and 3
    bus.skip_mask = 5'b01010; bus.run = 1'b1;
    tick(1);  chk("skip_idx0", 32'(bus.phase_idx), 32'd0);
    tick(1);  chk("skip_idx2", 32'(bus.phase_idx), 32'd2);
    tick(1);  chk("skip_idx4", 32'(bus.phase_idx), 32'd4);
    chk("skip_end", 32'(bus.cycle_end), 32'd1);
    tick(1);  chk("skip_wrap_cnt", 32'(bus.cycle_count), 32'd5);
    tick(1);

    // stall at idx 2 then restart
    bus.stall = 1'b1;
    tick(3);  chk("stall_en", 32'(bus.phase_en), 32'b00100);
    chk("stall_cnt", 32'(bus.cycle_count), 32'd5);
    bus.stall = 1'b0; bus.restart = 1'b1;
    tick(1);  bus.restart = 1'b0;
    chk("restart_idx", 32'(bus.phase_idx), 32'd0);
    chk("restart_cnt", 32'(bus.cycle_count), 32'd5);

    // phase 0 only
    bus.skip_mask = 5'b11110;
    tick(2);  chk("only0_cnt", 32'(bus.cycle_count), 32'd7);
    chk("only0_start", 32'(bus.cycle_start), 32'd1);
    chk("only0_end",   32'(bus.cycle_end),   32'd1);

    // reset mid-cycle at idx 3
    bus.skip_mask = 5'b00000;
    tick(3);  chk("pre_rst_idx", 32'(bus.phase_idx), 32'd3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_en",    32'(bus.phase_en),    32'd0);
    chk("mid_rst_idx",   32'(bus.phase_idx),   32'd0);
    chk("mid_rst_start", 32'(bus.cycle_start), 32'd0);
    chk("mid_rst_end",   32'(bus.cycle_end),   32'd0);
    chk("mid_rst_cnt",   32'(bus.cycle_count), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),        32'd0);

    // counter wrap at 2^CW-1
    rst = 1'b0; bus.skip_mask = 5'b11110;
    tick(1);  chk("wrap_start_cnt", 32'(bus.cycle_count), 32'd0);
    tick(15); chk("wrap_max_cnt",   32'(bus.cycle_count), 32'd15);
    tick(1);  chk("wrap_zero_cnt",  32'(bus.cycle_count), 32'd0);

    // restart while idle does nothing
    bus.run = 1'b0;
    tick(1);  chk("stop_busy", 32'(bus.busy), 32'd0);
    bus.restart = 1'b1;
    tick(1);  bus.restart = 1'b0;
    chk("idle_restart_busy", 32'(bus.busy), 32'd0);
    chk("idle_restart_en",   32'(bus.phase_en), 32'd0);
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
